// File: rtl/atm_login_controller.sv
// ATM login session controller: gathers account digit and 4-digit BCD PIN,
// presents them to the authenticator, and runs session, retry lockout and inactivity timeout.
module atm_login_controller #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_digit,
  input  logic        digit_valid,
  input  logic        enter,
  input  logic        cancel,
  input  logic        logout,
  input  logic        acc_found_stat,
  input  logic        acc_auth_stat,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [2:0]  pin_count,
  output logic        check_req,
  output logic        session_active,
  output logic        locked,
  output logic [2:0]  attempts_left,
  output logic [2:0]  status
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0]        MAX_TRIES = 3'(MAX_ATTEMPTS);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_NONE      = 3'd0;
  localparam logic [2:0] ST_OK        = 3'd1;
  localparam logic [2:0] ST_BAD_PIN   = 3'd2;
  localparam logic [2:0] ST_NO_ACC    = 3'd3;
  localparam logic [2:0] ST_LOCKED    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT   = 3'd5;
  localparam logic [2:0] ST_CANCELLED = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_ACC = 3'd1,
    GET_PIN = 3'd2,
    CHECK   = 3'd3,
    SESSION = 3'd4,
    LOCKED  = 3'd5
  } state_t;

  state_t            state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [TO_W-1:0]   idle_cnt;

  logic digit_ok;
  logic any_strobe;
  logic ev_cancel;
  logic ev_logout;
  logic ev_enter;
  logic ev_digit;
  logic timed;
  logic expired;

  // Only the highest-priority strobe of a cycle is acted on.
  assign digit_ok   = digit_valid && (key_digit <= 4'd9);
  assign any_strobe = digit_ok | enter | cancel | logout;
  assign ev_cancel  = cancel;
  assign ev_logout  = logout & ~cancel;
  assign ev_enter   = enter & ~cancel & ~logout;
  assign ev_digit   = digit_ok & ~cancel & ~logout & ~enter;
  assign timed      = (state == GET_ACC) || (state == GET_PIN) || (state == SESSION);
  assign expired    = timed && !any_strobe && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc_num        <= '0;
      pin            <= '0;
      pin_count      <= '0;
      check_req      <= 1'b0;
      session_active <= 1'b0;
      locked         <= 1'b0;
      attempts_left  <= MAX_TRIES;
      status         <= ST_NONE;
      lock_cnt       <= '0;
      idle_cnt       <= '0;
    end else begin
      // Timer runs only on quiet cycles of a timed state; entry from CHECK or a strobe clears it.
      if (timed && !any_strobe)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;

      if (expired) begin
        pin            <= '0;
        pin_count      <= '0;
        status         <= ST_TIMEOUT;
        session_active <= 1'b0;
        idle_cnt       <= '0;
        state          <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ev_digit) begin
              acc_num <= key_digit;
              status  <= ST_NONE;
              state   <= GET_ACC;
            end
          end
          GET_ACC: begin
            if (ev_cancel) begin
              status <= ST_CANCELLED;
              state  <= IDLE;
            end else if (ev_enter) begin
              pin       <= '0;
              pin_count <= '0;
              state     <= GET_PIN;
            end else if (ev_digit) begin
              acc_num <= key_digit;
            end
          end
          GET_PIN: begin
            if (ev_cancel) begin
              pin       <= '0;
              pin_count <= '0;
              status    <= ST_CANCELLED;
              state     <= IDLE;
            end else if (ev_enter) begin
              if (pin_count == 3'd4) begin
                check_req <= 1'b1;
                state     <= CHECK;
              end
            end else if (ev_digit && (pin_count < 3'd4)) begin
              pin       <= {pin[11:0], key_digit};
              pin_count <= pin_count + 3'd1;
            end
          end
          CHECK: begin
            check_req <= 1'b0;
            if (!acc_found_stat) begin
              status <= ST_NO_ACC;
              state  <= IDLE;
            end else if (acc_auth_stat) begin
              status         <= ST_OK;
              attempts_left  <= MAX_TRIES;
              session_active <= 1'b1;
              state          <= SESSION;
            end else if (attempts_left > 3'd1) begin
              attempts_left <= attempts_left - 3'd1;
              status        <= ST_BAD_PIN;
              pin           <= '0;
              pin_count     <= '0;
              state         <= GET_PIN;
            end else begin
              attempts_left <= 3'd0;
              status        <= ST_LOCKED;
              pin           <= '0;
              pin_count     <= '0;
              locked        <= 1'b1;
              lock_cnt      <= '0;
              state         <= LOCKED;
            end
          end
          SESSION: begin
            if (ev_cancel || ev_logout) begin
              pin            <= '0;
              pin_count      <= '0;
              status         <= ST_NONE;
              session_active <= 1'b0;
              state          <= IDLE;
            end
          end
          LOCKED: begin
            if (lock_cnt == LOCK_LAST) begin
              lock_cnt      <= '0;
              locked        <= 1'b0;
              attempts_left <= MAX_TRIES;
              status        <= ST_NONE;
              state         <= IDLE;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_login_controller.sv
// Bench for atm_login_controller: directed literal checks plus randomized
// strobes compared every cycle against a behavioural session model.
module tb_atm_login_controller;

  localparam int MAXA = 3;
  localparam int LOCKC = 8;
  localparam int TOC = 20;

  localparam int M_IDLE = 0, M_ACC = 1, M_PIN = 2, M_CHK = 3, M_SES = 4, M_LCK = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_digit = '0;
  logic        digit_valid = 1'b0;
  logic        enter = 1'b0;
  logic        cancel = 1'b0;
  logic        logout = 1'b0;
  logic        acc_found_stat;
  logic        acc_auth_stat;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [2:0]  pin_count;
  logic        check_req;
  logic        session_active;
  logic        locked;
  logic [2:0]  attempts_left;
  logic [2:0]  status;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_mode, m_acc, m_tries, m_status, m_idle, m_lock_left;
  int m_digits[$];

  always #5 clk = ~clk;

  atm_login_controller #(
    .MAX_ATTEMPTS(MAXA), .LOCK_CYCLES(LOCKC), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_digit(key_digit), .digit_valid(digit_valid),
    .enter(enter), .cancel(cancel), .logout(logout),
    .acc_found_stat(acc_found_stat), .acc_auth_stat(acc_auth_stat),
    .acc_num(acc_num), .pin(pin), .pin_count(pin_count), .check_req(check_req),
    .session_active(session_active), .locked(locked),
    .attempts_left(attempts_left), .status(status)
  );

  // Account database: 5 with PIN 1234, and 2 with any PIN starting with digit 1.
  function automatic bit db_found(input logic [3:0] a);
    return (a == 4'd5) || (a == 4'd2);
  endfunction

  function automatic bit db_auth(input logic [3:0] a, input logic [15:0] p);
    return ((a == 4'd5) && (p == 16'h1234)) || ((a == 4'd2) && (p[15:12] == 4'd1));
  endfunction

  assign acc_found_stat = db_found(acc_num);
  assign acc_auth_stat  = db_auth(acc_num, pin);

  function automatic int m_pin();
    int p = 0;
    foreach (m_digits[i]) p = p * 16 + m_digits[i];
    return p;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_acc = 0; m_tries = MAXA; m_status = 0;
    m_idle = 0; m_lock_left = 0;
    m_digits.delete();
  endtask

  task automatic model_step(input logic [3:0] d, input bit dv, input bit en,
                            input bit ca, input bit lo);
    bit dig;
    bit any;
    int ev;
    dig = dv && (d <= 4'd9);
    any = dig || en || ca || lo;
    ev = ca ? 1 : lo ? 2 : en ? 3 : dig ? 4 : 0;
    if ((m_mode == M_ACC || m_mode == M_PIN || m_mode == M_SES) && !any) begin
      m_idle++;
      if (m_idle >= TOC) begin
        m_digits.delete(); m_status = 5; m_mode = M_IDLE; m_idle = 0;
      end
      return;
    end
    m_idle = 0;
    case (m_mode)
      M_IDLE: if (ev == 4) begin m_acc = d; m_status = 0; m_mode = M_ACC; end
      M_ACC: begin
        if (ev == 1) begin m_status = 6; m_mode = M_IDLE; end
        else if (ev == 3) begin m_digits.delete(); m_mode = M_PIN; end
        else if (ev == 4) m_acc = d;
      end
      M_PIN: begin
        if (ev == 1) begin m_digits.delete(); m_status = 6; m_mode = M_IDLE; end
        else if (ev == 3 && m_digits.size() == 4) m_mode = M_CHK;
        else if (ev == 4 && m_digits.size() < 4) m_digits.push_back(int'(d));
      end
      M_CHK: begin
        if (!db_found(4'(m_acc))) begin
          m_status = 3; m_mode = M_IDLE;
        end else if (db_auth(4'(m_acc), 16'(m_pin()))) begin
          m_status = 1; m_tries = MAXA; m_mode = M_SES;
        end else if (m_tries > 1) begin
          m_tries--; m_status = 2; m_digits.delete(); m_mode = M_PIN;
        end else begin
          m_tries = 0; m_status = 4; m_digits.delete(); m_mode = M_LCK; m_lock_left = LOCKC;
        end
      end
      M_SES: if (ev == 1 || ev == 2) begin m_digits.delete(); m_status = 0; m_mode = M_IDLE; end
      M_LCK: begin
        m_lock_left--;
        if (m_lock_left == 0) begin m_tries = MAXA; m_status = 0; m_mode = M_IDLE; end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("acc_num", int'(acc_num), m_acc);
      cmp("pin", int'(pin), m_pin());
      cmp("pin_count", int'(pin_count), m_digits.size());
      cmp("check_req", int'(check_req), int'(m_mode == M_CHK));
      cmp("session_active", int'(session_active), int'(m_mode == M_SES));
      cmp("locked", int'(locked), int'(m_mode == M_LCK));
      cmp("attempts_left", int'(attempts_left), m_tries);
      cmp("status", int'(status), m_status);
    end
  end

  task automatic drive(input logic [3:0] d, input bit dv, input bit en,
                       input bit ca, input bit lo);
    key_digit = d; digit_valid = dv; enter = en; cancel = ca; logout = lo;
    @(posedge clk);
    model_step(d, dv, en, ca, lo);
    @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] d); drive(d, 1, 0, 0, 0); endtask
  task automatic ent();   drive(4'd0, 0, 1, 0, 0); endtask
  task automatic idle1(); drive(4'd0, 0, 0, 0, 0); endtask
  task automatic can();   drive(4'd0, 0, 0, 1, 0); endtask
  task automatic lgo();   drive(4'd0, 0, 0, 0, 1); endtask

  task automatic pin4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] e);
    dig(a); dig(b); dig(c); dig(e);
  endtask

  function automatic logic [3:0] pick_digit();
    int r = $urandom_range(0, 9);
    if (r < 2) return 4'd5;
    if (r < 4) return 4'd2;
    if (r < 6) return 4'd1;
    if (r < 7) return 4'($urandom_range(0, 9));
    if (r < 8) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(3, 4));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("rst_acc_num", int'(acc_num), 0);
    cmp("rst_pin", int'(pin), 0);
    cmp("rst_attempts", int'(attempts_left), 3);
    cmp("rst_status", int'(status), 0);
    cmp("rst_flags", int'({check_req, session_active, locked}), 0);
    rst_n = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);

    // Happy path
    dig(5); ent(); pin4(1, 2, 3, 4);
    cmp("happy_acc", int'(acc_num), 5);
    cmp("happy_pin", int'(pin), 'h1234);
    ent();
    cmp("happy_check_req", int'(check_req), 1);
    idle1();
    cmp("happy_check_req_drop", int'(check_req), 0);
    cmp("happy_session", int'(session_active), 1);
    cmp("happy_status", int'(status), 1);
    cmp("happy_attempts", int'(attempts_left), 3);
    lgo();
    cmp("logout_session", int'(session_active), 0);
    cmp("logout_pin", int'(pin), 0);

    // Wrong PIN three times leads to lockout
    dig(5); ent(); pin4(9, 9, 9, 9); ent(); idle1();
    cmp("bad1_status", int'(status), 2);
    cmp("bad1_attempts", int'(attempts_left), 2);
    pin4(9, 9, 9, 9); ent(); idle1();
    cmp("bad2_attempts", int'(attempts_left), 1);
    pin4(9, 9, 9, 9); ent(); idle1();
    cmp("lock_flag", int'(locked), 1);
    cmp("lock_status", int'(status), 4);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      can();
      if (locked) n++;
      else break;
    end
    cmp("lock_cycles", n, 8);
    cmp("unlock_status", int'(status), 0);
    cmp("unlock_attempts", int'(attempts_left), 3);

    // Unknown account
    dig(9); ent(); pin4(1, 2, 3, 4); ent(); idle1();
    cmp("noacc_status", int'(status), 3);
    cmp("noacc_attempts", int'(attempts_left), 3);
    cmp("noacc_idle", int'({check_req, session_active}), 0);

    // Short and long PIN, invalid digits
    dig(5); dig(4'hA);
    cmp("acc_ignores_A", int'(acc_num), 5);
    ent(); dig(1); dig(2); dig(3); ent(); idle1();
    cmp("short_pin_count", int'(pin_count), 3);
    cmp("short_no_check", int'(check_req), 0);
    dig(4); dig(7); dig(4'hA);
    cmp("long_pin", int'(pin), 'h1234);
    cmp("long_pin_count", int'(pin_count), 4);

    // Cancel beats enter
    drive(4'd0, 0, 1, 1, 0);
    cmp("prio_status", int'(status), 6);
    cmp("prio_pin_count", int'(pin_count), 0);
    idle1();
    cmp("prio_no_check", int'(check_req), 0);

    // Inactivity timeout in GET_PIN
    dig(5); ent(); dig(1);
    n = 0;
    while (status != 3'd5 && n < 40) begin
      idle1();
      n++;
    end
    cmp("timeout_cycles", n, 20);
    cmp("timeout_pin_count", int'(pin_count), 0);

    // Asynchronous reset mid-session
    dig(5); ent(); pin4(1, 2, 3, 4); ent(); idle1();
    cmp("pre_reset_session", int'(session_active), 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_session", int'(session_active), 0);
    cmp("async_rst_acc", int'(acc_num), 0);
    cmp("async_rst_pin", int'(pin), 0);
    cmp("async_rst_status", int'(status), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);

    // Randomized traffic with periodic quiet windows
    for (int seg = 0; seg < 40; seg++) begin
      for (int c = 0; c < 60; c++) begin
        int p;
        logic [3:0] d;
        p = $urandom_range(0, 99);
        d = pick_digit();
        if (p < 30) drive(d, 1, 0, 0, 0);
        else if (p < 45) ent();
        else if (p < 48) can();
        else if (p < 51) lgo();
        else if (p < 58) drive(d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        else idle1();
      end
      if (seg % 3 == 0) repeat (25) idle1();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
